// File: rtl/sideband_msg_serializer_if.sv
// Sideband serializer handshake bundle: message enqueue side plus serial link side.
// master = message producer / link consumer, slave = serializer.
interface sideband_msg_serializer_if #(
  parameter int MSG_W  = 4,
  parameter int DATA_W = 16
) ();
  logic              i_valid;
  logic [MSG_W-1:0]  i_encoded_sideband_message;
  logic [DATA_W-1:0] i_data_bits;
  logic              i_link_ready;
  logic              o_ser_data;
  logic              o_ser_valid;
  logic              o_frame_start;
  logic              o_busy;
  logic              o_busy_negedge_detected;
  logic              o_overflow;

  modport master (
    output i_valid,
    output i_encoded_sideband_message,
    output i_data_bits,
    output i_link_ready,
    input  o_ser_data,
    input  o_ser_valid,
    input  o_frame_start,
    input  o_busy,
    input  o_busy_negedge_detected,
    input  o_overflow
  );

  modport slave (
    input  i_valid,
    input  i_encoded_sideband_message,
    input  i_data_bits,
    input  i_link_ready,
    output o_ser_data,
    output o_ser_valid,
    output o_frame_start,
    output o_busy,
    output o_busy_negedge_detected,
    output o_overflow
  );
endinterface

// File: rtl/sideband_msg_serializer.sv
// Queues {message, data} words and shifts each out MSB-first as a sideband frame.
// Define SB_PARITY_EN to append an even-parity bit to every frame.
module sideband_msg_serializer #(
  parameter int MSG_W      = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  sideband_msg_serializer_if.slave sb
);
  localparam int WORD_W = MSG_W + DATA_W;
`ifdef SB_PARITY_EN
  localparam int FRAME_LEN = WORD_W + 1;
`else
  localparam int FRAME_LEN = WORD_W;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]           state, state_nx;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nx;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;
  logic [WORD_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count, count_nx;
  logic [FRAME_LEN-1:0] shreg, frame_word;
  logic [WORD_W-1:0]    head;
  logic                 busy, busy_nx, busy_fall;
  logic                 overflow;
  logic                 full, pop, push, drop;

  assign full = (count == CNT_W'(FIFO_DEPTH));
  assign pop  = (state == ST_IDLE) && (count != '0);
  // a pop in the same cycle frees the slot a full-queue push needs
  assign push = sb.i_valid && (!full || pop);
  assign drop = sb.i_valid && full && !pop;
  assign head = mem[rd_ptr];

`ifdef SB_PARITY_EN
  assign frame_word = {head, ^head};
`else
  assign frame_word = head;
`endif

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    unique case (state)
      ST_IDLE: begin
        if (pop) state_nx = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sb.i_link_ready) begin
          if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
            state_nx   = ST_GAP;
            bit_cnt_nx = '0;
          end else begin
            bit_cnt_nx = bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_nx   = ST_IDLE;
          gap_cnt_nx = '0;
        end else begin
          gap_cnt_nx = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    count_nx = count;
    unique case ({push, pop})
      2'b10:   count_nx = count + CNT_W'(1);
      2'b01:   count_nx = count - CNT_W'(1);
      default: count_nx = count;
    endcase
  end

  assign busy_nx = (count_nx != '0) || (state_nx != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sb.i_encoded_sideband_message,
                              sb.i_data_bits};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      busy_fall <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      gap_cnt   <= gap_cnt_nx;
      count     <= count_nx;
      busy      <= busy_nx;
      busy_fall <= busy & ~busy_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) overflow <= 1'b1;
      if (pop)
        shreg <= frame_word;
      else if (state == ST_SHIFT && sb.i_link_ready)
        shreg <= shreg << 1;
    end
  end

  assign sb.o_ser_data    = (state == ST_SHIFT) & shreg[FRAME_LEN-1];
  assign sb.o_ser_valid   = (state == ST_SHIFT) & sb.i_link_ready;
  assign sb.o_frame_start = (state == ST_SHIFT) & (bit_cnt == '0)
                          & sb.i_link_ready;
  assign sb.o_busy                  = busy;
  assign sb.o_busy_negedge_detected = busy_fall;
  assign sb.o_overflow              = overflow;
endmodule

// File: tb/tb_sideband_msg_serializer.sv
// Directed bench for sideband_msg_serializer; logs serial bits, frame starts and busy per cycle.
// Build with SB_PARITY_EN to exercise the parity frame format.
module tb_sideband_msg_serializer;
  localparam int MSG_W  = 4;
  localparam int DATA_W = 16;
  localparam int G      = 2;
`ifdef SB_PARITY_EN
  localparam int FL = 21;
  localparam logic [31:0] W_A1234 = 32'h142469;
  localparam logic [31:0] W_3BEEF = 32'h077DDF;
`else
  localparam int FL = 20;
  localparam logic [31:0] W_A1234 = 32'h0A1234;
  localparam logic [31:0] W_3BEEF = 32'h03BEEF;
`endif
  localparam int P = FL + G + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sideband_msg_serializer_if #(.MSG_W(MSG_W), .DATA_W(DATA_W)) sb ();

  sideband_msg_serializer #(
    .MSG_W(MSG_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(4), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sb(sb)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs    = 0;
  bit bits[$];
  int bit_cyc[$];
  int fs_cyc[$];
  int neg_cyc[$];
  bit busy_log[int];

  always @(negedge clk) begin
    busy_log[cyc] = sb.o_busy;
    if (sb.o_ser_valid) begin
      bits.push_back(sb.o_ser_data);
      bit_cyc.push_back(cyc);
    end
    if (sb.o_frame_start) fs_cyc.push_back(cyc);
    if (sb.o_busy_negedge_detected) neg_cyc.push_back(cyc);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_frame(logic [3:0] m,
                                            logic [15:0] d);
    logic [19:0] w;
    w = {m, d};
`ifdef SB_PARITY_EN
    return {11'b0, w, ^w};
`else
    return {12'b0, w};
`endif
  endfunction

  function automatic logic [31:0] frame_at(int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < FL; i++)
      if (k * FL + i < bits.size())
        v = {v[30:0], bits[k * FL + i]};
    return v;
  endfunction

  function automatic int busy_zeros(int a, int b);
    int n;
    n = 0;
    for (int c = a; c <= b; c++)
      if (busy_log.exists(c) && !busy_log[c]) n++;
    return n;
  endfunction

  function automatic logic [5:0] outs();
    return {sb.o_busy, sb.o_busy_negedge_detected, sb.o_overflow,
            sb.o_ser_valid, sb.o_ser_data, sb.o_frame_start};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    bits.delete();
    bit_cyc.delete();
    fs_cyc.delete();
    neg_cyc.delete();
    busy_log.delete();
  endtask

  task automatic run_single(input string tag,
                            input logic [3:0] m,
                            input logic [15:0] d,
                            input logic [31:0] w);
    int n;
    clear_logs();
    n = cyc;
    sb.i_valid = 1'b1;
    sb.i_encoded_sideband_message = m;
    sb.i_data_bits = d;
    step();
    sb.i_valid = 1'b0;
    repeat (30) step();
    check({tag, "_nbits"}, bits.size(), FL);
    check({tag, "_word"}, frame_at(0), w);
    check({tag, "_first_bit"}, bits.size() ? bit_cyc[0] : -1, n + 2);
    check({tag, "_last_bit"}, bits.size() ? bit_cyc[$] : -1, n + FL + 1);
    check({tag, "_nstart"}, fs_cyc.size(), 1);
    check({tag, "_start_cyc"}, fs_cyc.size() ? fs_cyc[0] : -1, n + 2);
    check({tag, "_busy_n"}, busy_log[n], 0);
    check({tag, "_busy_n1"}, busy_log[n + 1], 1);
    check({tag, "_busy_end"}, busy_log[n + FL + G + 1], 1);
    check({tag, "_busy_low"}, busy_log[n + FL + G + 2], 0);
    check({tag, "_nneg"}, neg_cyc.size(), 1);
    check({tag, "_neg_cyc"}, neg_cyc.size() ? neg_cyc[0] : -1,
          n + FL + G + 2);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    sb.i_valid = 1'b0;
    sb.i_encoded_sideband_message = '0;
    sb.i_data_bits = '0;
    sb.i_link_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("reset_outs", outs(), 6'b0);
    rst_n = 1'b1;
    step();

    run_single("t1", 4'hA, 16'h1234, W_A1234);

    // back-pressure on cycles N+5..N+7 holds bit 3
    clear_logs();
    n = cyc;
    sb.i_valid = 1'b1;
    sb.i_encoded_sideband_message = 4'hA;
    sb.i_data_bits = 16'h1234;
    step();
    sb.i_valid = 1'b0;
    for (int k = 0; k < 34; k++) begin
      sb.i_link_ready = !(cyc >= n + 5 && cyc <= n + 7);
      step();
    end
    sb.i_link_ready = 1'b1;
    check("t2_nbits", bits.size(), FL);
    check("t2_word", frame_at(0), W_A1234);
    check("t2_bit3_cyc", bits.size() > 3 ? bit_cyc[3] : -1, n + 8);
    check("t2_last_bit", bits.size() ? bit_cyc[$] : -1, n + FL + 4);
    check("t2_nneg", neg_cyc.size(), 1);
    check("t2_neg_cyc", neg_cyc.size() ? neg_cyc[0] : -1,
          n + FL + G + 5);

    // four back-to-back messages
    clear_logs();
    n = cyc;
    for (int i = 0; i < 4; i++) begin
      sb.i_valid = 1'b1;
      sb.i_encoded_sideband_message = 4'(i + 1);
      sb.i_data_bits = 16'h10F0 + 16'(i * 16'h1000);
      step();
    end
    sb.i_valid = 1'b0;
    repeat (100) step();
    check("t3_nstart", fs_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_start%0d", i),
            fs_cyc.size() > i ? fs_cyc[i] : -1, n + 2 + P * i);
      check($sformatf("t3_word%0d", i), frame_at(i),
            exp_frame(4'(i + 1), 16'h10F0 + 16'(i * 16'h1000)));
    end
    check("t3_nneg", neg_cyc.size(), 1);
    check("t3_neg_cyc", neg_cyc.size() ? neg_cyc[0] : -1,
          n + 2 + 3 * P + FL + G);
    check("t3_busy_gaps", busy_zeros(n + 1, n + 1 + 3 * P + FL + G), 0);

    // six messages: one popped, four queued, sixth dropped
    clear_logs();
    n = cyc;
    for (int i = 0; i < 6; i++) begin
      sb.i_valid = 1'b1;
      sb.i_encoded_sideband_message = 4'(i + 5);
      sb.i_data_bits = 16'h0A00 + 16'(i);
      if (i == 5) begin
        @(negedge clk);
        check("t4_ovf_before", sb.o_overflow, 0);
      end
      step();
    end
    sb.i_valid = 1'b0;
    @(negedge clk);
    check("t4_ovf_set", sb.o_overflow, 1);
    repeat (140) step();
    check("t4_ovf_sticky", sb.o_overflow, 1);
    check("t4_nstart", fs_cyc.size(), 5);
    check("t4_nbits", bits.size(), 5 * FL);
    for (int i = 0; i < 5; i++)
      check($sformatf("t4_word%0d", i), frame_at(i),
            exp_frame(4'(i + 5), 16'h0A00 + 16'(i)));
    check("t4_nneg", neg_cyc.size(), 1);

    // reset while bit 10 is on the wire, second message still queued
    clear_logs();
    n = cyc;
    sb.i_valid = 1'b1;
    sb.i_encoded_sideband_message = 4'hB;
    sb.i_data_bits = 16'h5555;
    step();
    sb.i_encoded_sideband_message = 4'hC;
    step();
    sb.i_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("t5_outs", outs(), 6'b0);
    rst_n = 1'b1;
    repeat (30) step();
    check("t5_nbits", bits.size(), 11);
    check("t5_nstart", fs_cyc.size(), 1);
    check("t5_nneg", neg_cyc.size(), 0);
    check("t5_busy_low", busy_zeros(n + 13, n + 40), 28);

    run_single("t5b", 4'h3, 16'hBEEF, W_3BEEF);
`ifdef SB_PARITY_EN
    run_single("t6a", 4'h1, 16'h0001, 32'h020002);
    run_single("t6b", 4'h1, 16'h0003, 32'h020007);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
